mul_seq_ctrl: RTL



---
 rtl/mul_seq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequential 12 x (4*NIBBLES) unsigned multiplier controller driving an external 12x4 array multiplier.
// Optional macro MUL_EARLY_TERM_EN: finish as soon as all remaining b slices are zero.
module mul_seq_ctrl #(
    parameter int NIBBLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [11:0]             in_a,
    input  logic [4*NIBBLES-1:0]    in_b,
    output logic [11:0]             mul_a,
    output logic [3:0]              mul_b,
    input  logic [15:0]             mul_p,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [12+4*NIBBLES-1:0] out_p
);

    localparam int BW = 4 * NIBBLES;
    localparam int PW = 12 + BW;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [KW-1:0]   k_r, k_nxt_s;
    logic [11:0]     a_r, a_nxt_s;
    logic [BW-1:0]   b_r, b_nxt_s;
    logic [PW-1:0]   acc_r, acc_nxt_s;
    logic [PW-1:0]   out_p_r, out_p_nxt_s;
    logic            in_ready_r, out_valid_r;
    logic [11:0]     mul_a_r;
    logic [3:0]      mul_b_r;
    logic [PW-1:0]   sum_s;
    logic            last_s;

`ifdef MUL_EARLY_TERM_EN
    function automatic logic upper_zero(input logic [BW-1:0] b, input logic [KW-1:0] k);
        logic z;
        z = 1'b1;
        for (int j = 0; j < NIBBLES; j++) begin
            if ((j > int'(k)) && (b[4*j +: 4] != 4'h0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction
`endif

    // Accumulate the current shifted partial product and decide whether this slice is the last.
    always_comb begin
        sum_s = acc_r + (PW'(mul_p) << {k_r, 2'b00});
`ifdef MUL_EARLY_TERM_EN
        last_s = (k_r == K_LAST) || upper_zero(b_r, k_r);
`else
        last_s = (k_r == K_LAST);
`endif
    end

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        acc_nxt_s   = acc_r;
        out_p_nxt_s = out_p_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CALC;
                    a_nxt_s     = in_a;
                    b_nxt_s     = in_b;
                    acc_nxt_s   = '0;
                    k_nxt_s     = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                acc_nxt_s = sum_s;
                if (last_s) begin
                    state_nxt_s = DONE;
                    out_p_nxt_s = sum_s;
                end else begin
                    k_nxt_s = k_r + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= '0;
            a_r         <= 12'h000;
            b_r         <= '0;
            acc_r       <= '0;
            out_p_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            mul_a_r     <= 12'h000;
            mul_b_r     <= 4'h0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            acc_r       <= acc_nxt_s;
            out_p_r     <= out_p_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            // Multiplier inputs are parked at zero outside CALC to limit toggling.
            if (state_nxt_s == CALC) begin
                mul_a_r <= a_nxt_s;
                mul_b_r <= b_nxt_s[{k_nxt_s, 2'b00} +: 4];
            end else begin
                mul_a_r <= 12'h000;
                mul_b_r <= 4'h0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign out_p     = out_p_r;

endmodule
